// File: rtl/motor_timer_pkg.sv
// -----------------------------------------------------------------------------
// motor_timer_pkg
// Shared definitions for the fan/motor timer path.
//   - timer_state_e : 2-bit timer-slot select. The slot mux and the motor FSM
//                     use the same type, so the encodings stay identical.
//   - CNT_W_DEF     : default width of the remaining-seconds counter.
//   - ts_onehot()   : one-hot decode of a slot select (bit0 = slot 1, 000 = off).
// -----------------------------------------------------------------------------
package motor_timer_pkg;

    typedef enum logic [1:0] {
        TS_OFF = 2'b00,
        TS_T1  = 2'b01,
        TS_T2  = 2'b10,
        TS_T3  = 2'b11
    } timer_state_e;

    localparam int CNT_W_DEF = 10;

    // One-hot view of the active slot. Off decodes to all zeros.
    function automatic logic [2:0] ts_onehot(input timer_state_e ts);
        logic [2:0] oh;
        oh = 3'b000;
        case (ts)
            TS_T1:   oh = 3'b001;
            TS_T2:   oh = 3'b010;
            TS_T3:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/down_counter_ld.sv
// -----------------------------------------------------------------------------
// down_counter_ld
// CNT_W-bit down counter with synchronous load, clear and decrement enable.
// Priority, highest first: i_reset > i_clear > i_load > i_dec.
// The counter does not wrap. A decrement at zero leaves it at zero.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset (count -> 0)
//   i_clear    synchronous clear (count -> 0)
//   i_load     load i_load_val
//   i_load_val value to load
//   i_dec      decrement by one (saturates at 0)
//   o_count    current count (registered)
//   o_is_one   high when o_count == 1 (decoded from the register)
// -----------------------------------------------------------------------------
module down_counter_ld #(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_is_one
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count  = count_q;
    assign o_is_one = (count_q == CNT_W'(1));

endmodule

// File: rtl/motor_timer_ctrl.sv
// -----------------------------------------------------------------------------
// motor_timer_ctrl
// Timer scheduler for the fan/motor PWM path. A debounced button steps through
// the slots OFF -> T1 -> T2 -> T3 -> OFF while the motor runs. Entering a slot
// loads that slot's preset. The preset counts down on 1 s ticks. On expiry the
// block pulses o_timeout for one cycle and returns to OFF.
// Precedence, highest first: reset > motor off > button > tick.
// Every output is a register or a decode of a register.
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_btn_timer    one-cycle pulse: request the next timer slot
//   i_tick_1s      one-cycle pulse once per second
//   i_motor_on     level, high while the motor is running
//   o_time_state   slot select (00 off, 01/10/11 slots 1/2/3)
//   o_time_onehot  one-hot of the active slot, bit0 = slot 1
//   o_remaining    seconds left, 0 when off
//   o_timer_active high when a slot is selected
//   o_timeout      one-cycle pulse on countdown expiry
// -----------------------------------------------------------------------------
module motor_timer_ctrl
    import motor_timer_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int T1_SEC = 60,
    parameter int T2_SEC = 180,
    parameter int T3_SEC = 300
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_timer,
    input  logic             i_tick_1s,
    input  logic             i_motor_on,
    output logic [1:0]       o_time_state,
    output logic [2:0]       o_time_onehot,
    output logic [CNT_W-1:0] o_remaining,
    output logic             o_timer_active,
    output logic             o_timeout
);

    // A preset of zero would never expire. A preset that does not fit in
    // CNT_W bits would be truncated. Both are rejected at elaboration.
    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if ((T1_SEC < 1) || (T1_SEC > CNT_MAX) ||
        (T2_SEC < 1) || (T2_SEC > CNT_MAX) ||
        (T3_SEC < 1) || (T3_SEC > CNT_MAX)) begin : g_bad_preset
        $error("motor_timer_ctrl: presets must lie in 1..2**CNT_W-1");
    end

    timer_state_e     state_q;
    timer_state_e     state_d;
    logic             timeout_q;
    logic             timeout_d;

    logic             cnt_clear;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_is_one;

    down_counter_ld #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (cnt_clear),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_dec      (cnt_dec),
        .o_count    (cnt_value),
        .o_is_one   (cnt_is_one)
    );

    // State register. The timeout pulse is registered here as well, so it
    // lines up with the edge that returns the state to OFF.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= TS_OFF;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic and counter control.
    always_comb begin
        state_d      = state_q;
        timeout_d    = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (!i_motor_on) begin
            // With the motor stopped the timer drops to OFF without a timeout.
            state_d   = TS_OFF;
            cnt_clear = 1'b1;
        end else if (i_btn_timer) begin
            // The button wins over a tick in the same cycle. The tick is
            // dropped, even when it would have expired the count.
            case (state_q)
                TS_OFF: begin
                    state_d      = TS_T1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T1_SEC);
                end
                TS_T1: begin
                    state_d      = TS_T2;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T2_SEC);
                end
                TS_T2: begin
                    state_d      = TS_T3;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(T3_SEC);
                end
                default: begin
                    state_d   = TS_OFF;
                    cnt_clear = 1'b1;
                end
            endcase
        end else if (i_tick_1s && (state_q != TS_OFF)) begin
            cnt_dec = 1'b1;
            if (cnt_is_one) begin
                // The last second has elapsed: go to OFF and pulse timeout.
                state_d   = TS_OFF;
                timeout_d = 1'b1;
            end
        end
    end

    // Output decode of the registers only.
    always_comb begin
        o_time_state   = state_q;
        o_time_onehot  = ts_onehot(state_q);
        o_timer_active = (state_q != TS_OFF);
        o_remaining    = cnt_value;
        o_timeout      = timeout_q;
    end

endmodule

// File: tb/tb_motor_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_timer_ctrl
// Directed bench for motor_timer_ctrl with T1=3, T2=5, T3=7 and CNT_W=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that point,
// which is after the edge that consumed the previous inputs.
// -----------------------------------------------------------------------------
module tb_motor_timer_ctrl;
    import motor_timer_pkg::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             btn;
    logic             tick;
    logic             motor_on;
    logic [1:0]       time_state;
    logic [2:0]       time_onehot;
    logic [CNT_W-1:0] remaining;
    logic             timer_active;
    logic             timeout;

    int tests_run;
    int tests_failed;
    int timeout_cycles;

    motor_timer_ctrl #(
        .CNT_W  (CNT_W),
        .T1_SEC (3),
        .T2_SEC (5),
        .T3_SEC (7)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_btn_timer    (btn),
        .i_tick_1s      (tick),
        .i_motor_on     (motor_on),
        .o_time_state   (time_state),
        .o_time_onehot  (time_onehot),
        .o_remaining    (remaining),
        .o_timer_active (timer_active),
        .o_timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and sample 1 ns later. The bench counts every
    // cycle in which timeout is seen high.
    task automatic step();
        @(posedge clk);
        #1;
        if (timeout) timeout_cycles++;
    endtask

    task automatic show(input string what);
        $display("[TB] %s -> state=%0d rem=%0d onehot=%b active=%0d timeout=%0d",
                 what, time_state, remaining, time_onehot, timer_active, timeout);
    endtask

    task automatic btn_pulse();
        btn = 1'b1;
        step();
        btn = 1'b0;
        show("btn");
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
        show("tick");
    endtask

    task automatic check_all(input string tag, input int st, input int rem,
                             input int oh, input int act, input int to);
        check_eq({tag, ".state"},   int'(time_state),   st);
        check_eq({tag, ".rem"},     int'(remaining),    rem);
        check_eq({tag, ".onehot"},  int'(time_onehot),  oh);
        check_eq({tag, ".active"},  int'(timer_active), act);
        check_eq({tag, ".timeout"}, int'(timeout),      to);
    endtask

    int exp_state  [4] = '{1, 2, 3, 0};
    int exp_rem    [4] = '{3, 5, 7, 0};
    int exp_onehot [4] = '{1, 2, 4, 0};

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        timeout_cycles = 0;
        reset    = 1'b1;
        btn      = 1'b0;
        tick     = 1'b0;
        motor_on = 1'b0;

        // Reset, then idle ticks in OFF.
        step();
        step();
        show("reset");
        check_all("reset", 0, 0, 0, 0, 0);
        reset    = 1'b0;
        motor_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_pulse();
            check_all("idle_tick", 0, 0, 0, 0, 0);
        end

        // Slot cycling: four button pulses spaced 5 cycles apart.
        for (int i = 0; i < 4; i++) begin
            btn_pulse();
            check_all("cycle", exp_state[i], exp_rem[i], exp_onehot[i],
                      (exp_state[i] != 0) ? 1 : 0, 0);
            for (int j = 0; j < 4; j++) step();
            check_eq("cycle_hold.state", int'(time_state), exp_state[i]);
        end

        // Expiry from slot 1.
        btn_pulse();
        check_all("exp_load", 1, 3, 1, 1, 0);
        tick_pulse();
        check_all("exp_t1", 1, 2, 1, 1, 0);
        tick_pulse();
        check_all("exp_t2", 1, 1, 1, 1, 0);
        tick_pulse();
        check_all("exp_t3", 0, 0, 0, 0, 1);
        step();
        show("idle");
        check_eq("exp_pulse_end", int'(timeout), 0);
        tick_pulse();
        check_all("exp_sat", 0, 0, 0, 0, 0);

        // A button and a tick in the same cycle with remaining == 1.
        btn_pulse();
        tick_pulse();
        tick_pulse();
        check_all("bt_pre", 1, 1, 1, 1, 0);
        btn  = 1'b1;
        tick = 1'b1;
        step();
        btn  = 1'b0;
        tick = 1'b0;
        show("btn+tick");
        check_all("bt_same", 2, 5, 2, 1, 0);
        step();
        check_eq("bt_after.timeout", int'(timeout), 0);

        // Motor drops in T3 with remaining == 4.
        btn_pulse();
        for (int i = 0; i < 3; i++) tick_pulse();
        check_all("md_pre", 3, 4, 4, 1, 0);
        motor_on = 1'b0;
        step();
        show("motor_off");
        check_all("md_off", 0, 0, 0, 0, 0);
        btn_pulse();
        check_all("md_btn", 0, 0, 0, 0, 0);
        step();
        check_eq("md_after.timeout", int'(timeout), 0);

        // Reset and a tick together, in T2 with remaining == 3.
        motor_on = 1'b1;
        btn_pulse();
        btn_pulse();
        tick_pulse();
        tick_pulse();
        check_all("rst_pre", 2, 3, 2, 1, 0);
        reset = 1'b1;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        show("reset+tick");
        check_all("rst_mid", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        check_all("rst_after", 0, 0, 0, 0, 0);

        // The run contains exactly one legitimate expiry.
        check_eq("timeout_total", timeout_cycles, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
